wb_bus_arbiter: RTL and testbench

//  Shares the single processor Wishbone master port between instruction fetch (m0) and

---
 rtl/wb_bus_arbiter.sv | 118 +++++++++++
 tb/tb_wb_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: one grant per bus tenure, alternating on contention,
// with an optional stalled-strobe timeout that aborts the tenure and pulses err.
module wb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        grant_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        r_state;
  logic          r_grant;
  logic [CW-1:0] r_cnt;

  logic w_busy;
  logic w_g_cyc;
  logic w_g_stb;
  logic w_timeout;

  assign w_busy  = (r_state == BUSY);
  assign w_g_cyc = r_grant ? m1_cyc_i : m0_cyc_i;
  assign w_g_stb = r_grant ? m1_stb_i : m0_stb_i;

  // Bus outputs follow the granted master only while a tenure is live.
  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_stb_o = 1'b0;
    wb_cyc_o = 1'b0;
    if (w_busy) begin
      wb_adr_o = r_grant ? m1_adr_i : m0_adr_i;
      wb_dat_o = r_grant ? m1_dat_i : m0_dat_i;
      wb_we_o  = r_grant ? m1_we_i  : m0_we_i;
      wb_sel_o = r_grant ? m1_sel_i : m0_sel_i;
      wb_stb_o = w_g_stb;
      wb_cyc_o = w_g_cyc;
    end
  end

  // Timeout never fires together with ack, so ack and err stay mutually exclusive.
  assign w_timeout = (TIMEOUT_CYCLES > 0) && wb_stb_o && !wb_ack_i && (r_cnt == LAST);

  assign m0_ack_o = w_busy & ~r_grant & wb_ack_i;
  assign m1_ack_o = w_busy &  r_grant & wb_ack_i;
  assign m0_err_o = w_timeout & ~r_grant;
  assign m1_err_o = w_timeout &  r_grant;
  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;
  assign grant_o  = r_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0_cyc_i || m1_cyc_i) begin
            r_state <= BUSY;
            r_grant <= (m0_cyc_i && m1_cyc_i) ? ~r_grant : m1_cyc_i;
          end
        end
        BUSY: begin
          if (TIMEOUT_CYCLES == 0 || wb_ack_i || !wb_stb_o)
            r_cnt <= '0;
          else
            r_cnt <= r_cnt + CW'(1);
          if (!w_g_cyc)
            r_state <= IDLE;
          else if (w_timeout)
            r_state <= ABORT;
        end
        ABORT: begin
          r_cnt <= '0;
          if (!w_g_cyc)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: vector table for arbitration/muxing, hand sequences
// for timeout, abort, disabled timeout and asynchronous reset.
module tb_wb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] m0_adr_i = '0, m0_dat_i = 32'h0000_00A0;
  logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0;
  logic [3:0]  m0_sel_i = 4'h3;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic        m1_we_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
  logic [3:0]  m1_sel_i = 4'hF;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  logic [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, grant_o;
  logic [3:0]  wb_sel_o;

  logic [31:0] nt_m0_dat_o, nt_m1_dat_o, nt_wb_adr_o, nt_wb_dat_o;
  logic        nt_m0_ack_o, nt_m0_err_o, nt_m1_ack_o, nt_m1_err_o;
  logic        nt_wb_we_o, nt_wb_stb_o, nt_wb_cyc_o, nt_grant_o;
  logic [3:0]  nt_wb_sel_o;

  always #5 clk_i = ~clk_i;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .grant_o(grant_o)
  );

  wb_bus_arbiter #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(nt_m0_dat_o), .m0_ack_o(nt_m0_ack_o),
    .m0_err_o(nt_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(nt_m1_dat_o), .m1_ack_o(nt_m1_ack_o),
    .m1_err_o(nt_m1_err_o),
    .wb_adr_o(nt_wb_adr_o), .wb_dat_o(nt_wb_dat_o), .wb_we_o(nt_wb_we_o), .wb_sel_o(nt_wb_sel_o),
    .wb_stb_o(nt_wb_stb_o), .wb_cyc_o(nt_wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .grant_o(nt_grant_o)
  );

  typedef struct {
    bit          rst;
    bit          m0c, m0s;
    logic [31:0] m0a;
    bit          m1c, m1s, m1w;
    logic [3:0]  m1sel;
    logic [31:0] m1a, m1d;
    bit          ack;
    logic [31:0] rd;
    logic [139:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit rst, bit m0c, bit m0s, logic [31:0] m0a,
                              bit m1c, bit m1s, bit m1w, logic [3:0] m1sel,
                              logic [31:0] m1a, logic [31:0] m1d, bit ack, logic [31:0] rd,
                              bit ec, bit es, bit ew, logic [3:0] esel, logic [31:0] eadr,
                              logic [31:0] edat, bit eg, bit ea0, bit ea1, bit ee0, bit ee1);
    vec_t v;
    v.rst = rst; v.m0c = m0c; v.m0s = m0s; v.m0a = m0a;
    v.m1c = m1c; v.m1s = m1s; v.m1w = m1w; v.m1sel = m1sel; v.m1a = m1a; v.m1d = m1d;
    v.ack = ack; v.rd = rd;
    v.exp = {ec, es, ew, esel, eadr, edat, eg, ea0, ea1, ee0, ee1, rd, rd};
    return v;
  endfunction

  function automatic logic [139:0] pack();
    return {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, grant_o,
            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
  endfunction

  task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = '0; m1_dat_i = '0;
    wb_ack_i = 0; wb_dat_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit err_seen;

    // Test 1: single master read
    tbl.push_back(mk(1, 0,0,32'h0,   0,0,0,4'h0,32'h0,32'h0, 0,32'h0,        0,0,0,4'h0,32'h0,32'h0,   1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 0,0,0,4'h0,32'h0,32'h0, 0,32'h0,        0,0,0,4'h0,32'h0,32'h0,   1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 0,0,0,4'h0,32'h0,32'h0, 1,32'hCAFE0000, 1,1,0,4'h3,32'h100,32'hA0, 0,1,0,0,0));
    tbl.push_back(mk(0, 0,0,32'h100, 0,0,0,4'h0,32'h0,32'h0, 0,32'h0,        0,0,0,4'h3,32'h100,32'hA0, 0,0,0,0,0));
    // Test 2: simultaneous requests alternate m0, m1, m0, m1
    tbl.push_back(mk(1, 1,1,32'h100, 1,1,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'h0,32'h0,32'h0,    1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,0,4'hF,32'h200,32'h0, 1,32'h11, 1,1,0,4'h3,32'h100,32'hA0, 0,1,0,0,0));
    tbl.push_back(mk(0, 0,0,32'h100, 1,1,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'h3,32'h100,32'hA0, 0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,32'h100, 1,1,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'h0,32'h0,32'h0,    0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,32'h100, 1,1,0,4'hF,32'h200,32'h0, 1,32'h22, 1,1,0,4'hF,32'h200,32'h0,  1,0,1,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 0,0,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'hF,32'h200,32'h0,  1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'h0,32'h0,32'h0,    1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,0,4'hF,32'h200,32'h0, 1,32'h33, 1,1,0,4'h3,32'h100,32'hA0, 0,1,0,0,0));
    tbl.push_back(mk(0, 0,0,32'h100, 1,1,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'h3,32'h100,32'hA0, 0,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,0,4'hF,32'h200,32'h0, 0,32'h0,  0,0,0,4'h0,32'h0,32'h0,    0,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,0,4'hF,32'h200,32'h0, 1,32'h44, 1,1,0,4'hF,32'h200,32'h0,  1,0,1,0,0));
    // Test 3: m1 write tenure with m0 waiting
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,1,4'hF,32'h2000,32'h12345678, 0,32'h0,  1,1,1,4'hF,32'h2000,32'h12345678, 1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 1,1,1,4'hF,32'h2000,32'h12345678, 1,32'h55, 1,1,1,4'hF,32'h2000,32'h12345678, 1,0,1,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 0,0,1,4'hF,32'h2000,32'h12345678, 0,32'h0,  0,0,1,4'hF,32'h2000,32'h12345678, 1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 0,0,0,4'hF,32'h2000,32'h0,        0,32'h0,  0,0,0,4'h0,32'h0,32'h0,           1,0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h100, 0,0,0,4'hF,32'h2000,32'h0,        1,32'h66, 1,1,0,4'h3,32'h100,32'hA0,        0,1,0,0,0));
    tbl.push_back(mk(0, 0,0,32'h100, 0,0,0,4'hF,32'h2000,32'h0,        0,32'h0,  0,0,0,4'h3,32'h100,32'hA0,        0,0,0,0,0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0s; m0_adr_i = tbl[i].m0a;
      m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1s; m1_we_i = tbl[i].m1w;
      m1_sel_i = tbl[i].m1sel; m1_adr_i = tbl[i].m1a; m1_dat_i = tbl[i].m1d;
      wb_ack_i = tbl[i].ack; wb_dat_i = tbl[i].rd;
      @(negedge clk_i);
      chk($sformatf("vec%0d", i), pack(), tbl[i].exp);
      next_cycle();
    end

    // Test 4: stalled strobe times out on the 4th stb cycle, then abort
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300;
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      chk($sformatf("to_err_c%0d", k), {wb_cyc_o, m1_ack_o, m1_err_o, m0_err_o},
          {1'b1, 1'b0, (k == 4), 1'b0});
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk($sformatf("abort_c%0d", k), {wb_cyc_o, wb_stb_o, m1_err_o, m1_ack_o}, 4'b0000);
      next_cycle();
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    next_cycle();
    m1_cyc_i = 1; m1_stb_i = 1;
    @(negedge clk_i);
    chk("abort_idle", wb_cyc_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    chk("abort_regrant", {wb_cyc_o, grant_o}, 2'b11);

    // Test 5a: ack in the threshold cycle wins over timeout
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      wb_ack_i = (k == 4);
      @(negedge clk_i);
      chk($sformatf("thr_c%0d", k), {wb_cyc_o, m1_ack_o, m1_err_o}, {1'b1, (k == 4), 1'b0});
      next_cycle();
    end
    wb_ack_i = 0;

    // Test 5b: timeout disabled keeps tenure open indefinitely
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    err_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_i);
      if (nt_m1_err_o || nt_m0_err_o) err_seen = 1;
      next_cycle();
    end
    chk("nt_no_err", err_seen, 1'b0);
    @(negedge clk_i);
    chk("nt_cyc_open", {nt_wb_cyc_o, nt_grant_o}, 2'b11);

    // Test 6: asynchronous reset mid-tenure
    do_reset();
    m1_cyc_i = 0; m1_stb_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    next_cycle();
    @(negedge clk_i);
    chk("rst_pre", {wb_cyc_o, grant_o}, 2'b10);
    #1 rst_i = 1'b1;
    #1 chk("rst_async", {wb_cyc_o, wb_stb_o, grant_o}, 3'b001);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_idle", {wb_cyc_o, grant_o}, 2'b01);
    next_cycle();
    @(negedge clk_i);
    chk("rst_regrant", {wb_cyc_o, grant_o, wb_adr_o}, {2'b10, 32'h100});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
